dn_write_arbiter: RTL and testbench
===================================

Name: dn_write_arbiter

Overview:
- Merges the two download write sources into the single ht1080z download port (dn_go/dn_wr/dn_addr/dn_data):
  - raw HPS ioctl stream (ROM, cassette);
  - cmd_loader output (CMD records).
- Paces writes to the RAM write-slot rate through a small FIFO, backpressures HPS via ioctl_wait, and defers the loader's execute request until every queued byte has landed.
- Sits in emu between hps_io/cmd_loader and ht1080z.

Parameters:
- FIFO_DEPTH, 4: write-queue entries (power of two, ≥2).
- WR_GAP, 4: minimum clk_sys cycles from one dn_wr pulse to the next (≥1).
- CMD_INDEX, 2: ioctl_index value owned by cmd_loader; these bytes are never queued directly.

Ports:
- clk_sys  in  1  system clock (42 MHz).
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  HPS file index.
- ioctl_wr  in  1  HPS byte strobe.
- ioctl_addr  in  16  HPS byte address.
- ioctl_dout  in  8  HPS byte.
- ioctl_wait  out  1  backpressure to HPS.
- loader_download  in  1  cmd_loader active.
- loader_wr  in  1  cmd_loader byte strobe.
- loader_addr  in  16  cmd_loader target address.
- loader_data  in  8  cmd_loader byte.
- loader_exec_en  in  1  cmd_loader execute request (level or pulse).
- loader_exec_addr  in  16  cmd_loader entry point.
- dn_ready  in  1  RAM write slot free this cycle.
- dn_go  out  1  download window to ht1080z.
- dn_wr  out  1  one-cycle write strobe.
- dn_addr  out  24  write address.
- dn_data  out  8  write data.
- execute_enable  out  1  one-cycle execute pulse.
- execute_addr  out  16  entry point, valid with execute_enable and held after.
- overflow  out  1  sticky: a write was dropped on a full FIFO.

Behaviour:
- Reset (synchronous, active-high) takes effect on the next clk_sys edge:
  - flushes the FIFO, clears the gap counter, pending-exec flag and overflow;
  - forces state IDLE;
  - drives all outputs to 0.
- Source select, evaluated each cycle:
  - loader_download=1: push {8'h00, loader_addr, loader_data} on loader_wr; ioctl_wr is ignored because cmd_loader consumes those bytes.
  - else ioctl_download=1 and ioctl_index≠CMD_INDEX: push {7'b0, |ioctl_index, ioctl_addr, ioctl_dout} on ioctl_wr.
  - Otherwise no push.
- Push on a full FIFO: entry dropped, overflow set until reset.
- ioctl_wait:
  - registered; 1 when count ≥ FIFO_DEPTH-1 after this cycle's push/pop;
  - also 1 while state is DRAIN or EXEC with ioctl_download=1;
  - otherwise 0.
  - Guarantees room for one in-flight byte.
- Pop and pace:
  - gap counter gap_cnt decrements to 0 each cycle.
  - When FIFO non-empty, gap_cnt=0 and dn_ready=1: pop; the next cycle has dn_wr=1 with the registered dn_addr/dn_data of that entry; gap_cnt loads WR_GAP-1.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- dn_addr/dn_data hold their last popped value between strobes.
- FSM:
  - IDLE: dn_go=0. Goes to ACTIVE when ioctl_download or loader_download rises.
  - ACTIVE: dn_go=1. Goes to DRAIN when both downloads are 0.
  - DRAIN: dn_go=1. Goes to EXEC when the FIFO is empty and no dn_wr is pending; goes back to ACTIVE if a download restarts.
  - EXEC: dn_go drops to 0 this cycle. If pending_exec, assert execute_enable for this single cycle with execute_addr, then IDLE; else IDLE directly.
- pending_exec:
  - set and loader_exec_addr latched on any cycle loader_exec_en=1 (not in IDLE);
  - cleared on leaving EXEC.
  - A second request overwrites the latched address.
- Latency: from push into an empty FIFO with gap_cnt=0 and dn_ready=1, dn_wr is 2 cycles after the input strobe.
- Reset mid-transfer discards queued bytes and any pending execute; after reset the block waits in IDLE for a fresh download edge.

Decomposition:
- Shared package dn_pkg:
  - typedef dn_entry_t {addr[23:0], data[7:0]};
  - localparams CAS_BANK_BIT=16 and CMD_INDEX default;
  - FSM state enum {IDLE, ACTIVE, DRAIN, EXEC}.
- One sub-module dn_fifo: synchronous FWFT FIFO of dn_entry_t with count, full and empty outputs.

Test Plan:
- ROM/cassette path: ioctl_index=1, 8 back-to-back ioctl_wr at addr 0x0000..0x0007, dn_ready=1, WR_GAP=4 → dn_wr pulses 4 cycles apart, dn_addr 0x010000..0x010007, data in order; ioctl_wait rises when count reaches 3; overflow=0.
- Backpressure honoured: dn_ready held 0 for 20 cycles during an ioctl stream that obeys ioctl_wait → no drops, overflow=0; all bytes emerge once dn_ready=1.
- Overflow: 6 ioctl_wr ignoring ioctl_wait with dn_ready=0 → 4 bytes written, overflow=1 and sticky until reset.
- CMD load: loader writes 0x5200..0x5203 then loader_exec_en with 0x5200 → execute_enable pulses exactly once, 1 cycle, only after the 4th dn_wr and the cycle dn_go falls; execute_addr=0x5200.
- Index filter: ioctl_index=2 with loader_download=0 → no dn_wr, dn_go follows ioctl_download.
- Reset mid-op: assert reset with 3 entries queued and pending exec → next cycle all outputs 0, no later dn_wr or execute_enable.

Source files
------------

// File: rtl/dn_pkg.sv
// Shared types and constants for the download write arbiter.
package dn_pkg;

   // Address bit that separates the ROM bank from the cassette/alternate bank
   localparam int         CAS_BANK_BIT      = 16;
   // ioctl_index value whose bytes belong to cmd_loader
   localparam logic [7:0] DEFAULT_CMD_INDEX = 8'd2;

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  data;
   } dn_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      EXEC
   } dn_state_t;

   // Build a queue entry for a raw HPS byte: any non-zero index selects the upper bank
   function automatic dn_entry_t hps_entry(input logic [7:0]  index,
                                           input logic [15:0] addr,
                                           input logic [7:0]  data);
      dn_entry_t e;
      e.addr               = 24'h000000;
      e.addr[15:0]         = addr;
      e.addr[CAS_BANK_BIT] = |index;
      e.data               = data;
      return e;
   endfunction

endpackage

// File: rtl/dn_fifo.sv
// Synchronous first-word-fall-through FIFO of download entries.
// Push on full and pop on empty are ignored; the head entry is always on dout.
module dn_fifo
   import dn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  dn_entry_t     din,
   input  logic          pop,
   output dn_entry_t     dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dn_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dn_write_arbiter.sv
// Merges the HPS ioctl stream and cmd_loader writes into the ht1080z download port.
// Writes are queued, then paced out at most one per WR_GAP cycles when the RAM slot
// is free. The loader's execute request is held back until the queue has fully landed.
module dn_write_arbiter
   import dn_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter int         WR_GAP     = 4,
   parameter logic [7:0] CMD_INDEX  = DEFAULT_CMD_INDEX
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        loader_download,
   input  logic        loader_wr,
   input  logic [15:0] loader_addr,
   input  logic [7:0]  loader_data,
   input  logic        loader_exec_en,
   input  logic [15:0] loader_exec_addr,
   input  logic        dn_ready,
   output logic        dn_go,
   output logic        dn_wr,
   output logic [23:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        execute_enable,
   output logic [15:0] execute_addr,
   output logic        overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

   dn_state_t     state;
   logic          prev_ioctl_dl;
   logic          prev_loader_dl;
   logic          any_dl;
   logic          ioctl_rise;
   logic          loader_rise;
   logic [GW-1:0] gap_cnt;
   logic          pending_exec;
   logic [15:0]   exec_addr_q;

   logic          push_req;
   logic          push_ok;
   logic          pop;
   dn_entry_t     push_entry;
   dn_entry_t     head;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          full;
   logic          empty;

   assign any_dl      = ioctl_download || loader_download;
   assign ioctl_rise  = ioctl_download && !prev_ioctl_dl;
   assign loader_rise = loader_download && !prev_loader_dl;

   // Source select: the loader owns the port while active, otherwise non-CMD HPS bytes
   always_comb begin
      push_req   = 1'b0;
      push_entry = '0;
      if (loader_download) begin
         push_req        = loader_wr;
         push_entry.addr = {8'h00, loader_addr};
         push_entry.data = loader_data;
      end else if (ioctl_download && (ioctl_index != CMD_INDEX)) begin
         push_req   = ioctl_wr;
         push_entry = hps_entry(ioctl_index, ioctl_addr, ioctl_dout);
      end
   end

   assign push_ok    = push_req && !full;
   assign pop        = !empty && (gap_cnt == '0) && dn_ready;
   assign count_next = count + CW'(push_ok) - CW'(pop);

   dn_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk_sys),
      .reset (reset),
      .push  (push_ok),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Pacing, write strobe, backpressure and sticky overflow
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         gap_cnt    <= '0;
         dn_wr      <= 1'b0;
         dn_addr    <= '0;
         dn_data    <= '0;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dn_wr <= pop;
         if (pop) begin
            dn_addr <= head.addr;
            dn_data <= head.data;
            gap_cnt <= GW'(WR_GAP - 1);
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
         if (push_req && full) overflow <= 1'b1;
         // Raised one entry early so a byte already in flight from HPS still fits
         ioctl_wait <= (count_next >= CW'(FIFO_DEPTH - 1)) ||
                       (((state == DRAIN) || (state == EXEC)) && ioctl_download);
      end
   end

   // Download window FSM with deferred execute; outputs are registered alongside state
   always_ff @(posedge clk_sys) begin
      // On reset the edge detectors load the live levels, so a download still
      // asserted through reset is not mistaken for a fresh start.
      prev_ioctl_dl  <= ioctl_download;
      prev_loader_dl <= loader_download;
      if (reset) begin
         state          <= IDLE;
         dn_go          <= 1'b0;
         execute_enable <= 1'b0;
         execute_addr   <= '0;
         pending_exec   <= 1'b0;
         exec_addr_q    <= '0;
      end else begin
         execute_enable <= 1'b0;
         if (loader_exec_en && (state != IDLE)) begin
            pending_exec <= 1'b1;
            exec_addr_q  <= loader_exec_addr;
         end
         case (state)
            IDLE: begin
               if (ioctl_rise || loader_rise) begin
                  state <= ACTIVE;
                  dn_go <= 1'b1;
               end
            end
            ACTIVE: begin
               if (!any_dl) state <= DRAIN;
            end
            DRAIN: begin
               if (any_dl) begin
                  state <= ACTIVE;
               end else if (empty && !dn_wr) begin
                  state <= EXEC;
                  dn_go <= 1'b0;
                  if (pending_exec || loader_exec_en) begin
                     execute_enable <= 1'b1;
                     execute_addr   <= loader_exec_en ? loader_exec_addr : exec_addr_q;
                  end
               end
            end
            EXEC: begin
               state        <= IDLE;
               pending_exec <= 1'b0;
            end
            default: begin
               state <= IDLE;
               dn_go <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dn_write_arbiter.sv
// Directed bench for dn_write_arbiter: stimulus pushes expected writes/executes into
// queues, an independent monitor pops and compares whenever the DUT strobes.
module tb_dn_write_arbiter;

   localparam int FIFO_DEPTH = 4;
   localparam int WR_GAP     = 4;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index    = 8'h00;
   logic        ioctl_wr       = 1'b0;
   logic [15:0] ioctl_addr     = 16'h0000;
   logic [7:0]  ioctl_dout     = 8'h00;
   logic        ioctl_wait;
   logic        loader_download  = 1'b0;
   logic        loader_wr        = 1'b0;
   logic [15:0] loader_addr      = 16'h0000;
   logic [7:0]  loader_data      = 8'h00;
   logic        loader_exec_en   = 1'b0;
   logic [15:0] loader_exec_addr = 16'h0000;
   logic        dn_ready         = 1'b1;
   logic        dn_go;
   logic        dn_wr;
   logic [23:0] dn_addr;
   logic [7:0]  dn_data;
   logic        execute_enable;
   logic [15:0] execute_addr;
   logic        overflow;

   dn_write_arbiter #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WR_GAP     (WR_GAP),
      .CMD_INDEX  (8'd2)
   ) dut (
      .clk_sys          (clk_sys),
      .reset            (reset),
      .ioctl_download   (ioctl_download),
      .ioctl_index      (ioctl_index),
      .ioctl_wr         (ioctl_wr),
      .ioctl_addr       (ioctl_addr),
      .ioctl_dout       (ioctl_dout),
      .ioctl_wait       (ioctl_wait),
      .loader_download  (loader_download),
      .loader_wr        (loader_wr),
      .loader_addr      (loader_addr),
      .loader_data      (loader_data),
      .loader_exec_en   (loader_exec_en),
      .loader_exec_addr (loader_exec_addr),
      .dn_ready         (dn_ready),
      .dn_go            (dn_go),
      .dn_wr            (dn_wr),
      .dn_addr          (dn_addr),
      .dn_data          (dn_data),
      .execute_enable   (execute_enable),
      .execute_addr     (execute_addr),
      .overflow         (overflow)
   );

   // ---------------- scoreboard state ----------------
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exec_q[$];
   bit          strict_gap    = 1'b0;
   int          last_wr_cyc   = -1;
   bit          lat_armed     = 1'b0;
   int          lat_issue_cyc = 0;
   bit          saw_wait      = 1'b0;
   int          exec_pulses   = 0;
   logic        prev_dn_go    = 1'b0;
   logic        prev_exec     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk_sys) begin
      logic [31:0] exp_w;
      logic [15:0] exp_x;
      if (!reset) begin
         if (ioctl_wait) saw_wait = 1'b1;
         if (execute_enable) begin
            if (exec_q.size() == 0) begin
               check("spurious_execute", 32'(execute_enable), 32'd0);
            end else begin
               exp_x = exec_q.pop_front();
               check("execute_addr", 32'(execute_addr), 32'(exp_x));
               check("exec_dn_go_low", 32'(dn_go), 32'd0);
               check("exec_on_dn_go_fall", 32'(prev_dn_go), 32'd1);
               check("exec_after_all_writes", 32'(exp_q.size()), 32'd0);
               check("exec_single_cycle", 32'(prev_exec), 32'd0);
            end
            exec_pulses++;
         end
         if (dn_wr) begin
            if (exp_q.size() == 0) begin
               check("spurious_dn_wr", 32'(dn_wr), 32'd0);
            end else begin
               exp_w = exp_q.pop_front();
               check("dn_wr_entry", {dn_addr, dn_data}, exp_w);
            end
            if (last_wr_cyc >= 0) begin
               if (strict_gap) check("wr_gap_exact", 32'(cyc - last_wr_cyc), 32'(WR_GAP));
               else            check("wr_gap_min", 32'(cyc - last_wr_cyc >= WR_GAP), 32'd1);
            end
            last_wr_cyc = cyc;
            if (lat_armed) begin
               check("first_write_latency", 32'(cyc - lat_issue_cyc), 32'd2);
               lat_armed = 1'b0;
            end
         end
         prev_dn_go = dn_go;
         prev_exec  = execute_enable;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic hps_write(input logic [15:0] a, input logic [7:0] d, input bit obey,
                            input bit expect_it, input logic [31:0] exp_w);
      int guard = 0;
      if (obey) begin
         while (ioctl_wait && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200) check("ioctl_wait_timeout", 32'(ioctl_wait), 32'd0);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (expect_it) exp_q.push_back(exp_w);
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic loader_write(input logic [15:0] a, input logic [7:0] d);
      loader_wr   = 1'b1;
      loader_addr = a;
      loader_data = d;
      exp_q.push_back({8'h00, a, d});
      tick();
      loader_wr = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         tick();
         g++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while (dn_go && g < 100) begin
         tick();
         g++;
      end
      check(name, 32'(dn_go), 32'd0);
      tick(3);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
      check({tag, "_dn_go"}, 32'(dn_go), 32'd0);
      check({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
      check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
      check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
      check({tag, "_execute_enable"}, 32'(execute_enable), 32'd0);
      check({tag, "_execute_addr"}, 32'(execute_addr), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required finish (cycle %0d)", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      tick(3);
      reset = 1'b0;
      check_all_zero("reset");

      // ROM path: bank bit from ioctl_index=1, pacing exactly WR_GAP, wait obeyed
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      tick(3);
      check("rom_dn_go", 32'(dn_go), 32'd1);
      last_wr_cyc   = -1;
      strict_gap    = 1'b1;
      saw_wait      = 1'b0;
      lat_issue_cyc = cyc;
      lat_armed     = 1'b1;
      for (int i = 0; i < 8; i++)
         hps_write(16'(i), 8'(8'hA0 + i), 1'b1, 1'b1, {8'h01, 16'(i), 8'(8'hA0 + i)});
      wait_drain("rom_drain");
      strict_gap = 1'b0;
      check("rom_saw_wait", 32'(saw_wait), 32'd1);
      check("rom_overflow", 32'(overflow), 32'd0);
      ioctl_download = 1'b0;
      wait_idle("rom_idle");
      check("rom_wait_low", 32'(ioctl_wait), 32'd0);

      // Backpressure: RAM slot stalled for 20 cycles, HPS honours ioctl_wait
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      tick(2);
      dn_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               hps_write(16'(16'h1000 + i), 8'(8'h30 + i), 1'b1, 1'b1,
                         {8'h00, 16'(16'h1000 + i), 8'(8'h30 + i)});
         end
         begin
            tick(20);
            check("bp_wait_high", 32'(ioctl_wait), 32'd1);
            dn_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_overflow", 32'(overflow), 32'd0);
      ioctl_download = 1'b0;
      wait_idle("bp_idle");

      // Overflow: six writes ignoring ioctl_wait into a stalled four-entry queue
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      tick(2);
      dn_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         hps_write(16'(16'h2000 + i), 8'(8'h50 + i), 1'b0, (i < 4),
                   {8'h01, 16'(16'h2000 + i), 8'(8'h50 + i)});
      tick();
      check("ovf_set", 32'(overflow), 32'd1);
      dn_ready = 1'b1;
      wait_drain("ovf_drain");
      ioctl_download = 1'b0;
      wait_idle("ovf_idle");
      check("ovf_sticky", 32'(overflow), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_wr_cyc = -1;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // CMD load with deferred execute
      exec_pulses     = 0;
      loader_download = 1'b1;
      tick(2);
      check("cmd_dn_go", 32'(dn_go), 32'd1);
      for (int i = 0; i < 4; i++) loader_write(16'(16'h5200 + i), 8'(8'hC0 + i));
      loader_exec_en   = 1'b1;
      loader_exec_addr = 16'h5200;
      exec_q.push_back(16'h5200);
      tick();
      loader_exec_en = 1'b0;
      tick(2);
      loader_download = 1'b0;
      wait_drain("cmd_drain");
      wait_idle("cmd_idle");
      check("cmd_exec_count", 32'(exec_pulses), 32'd1);
      check("cmd_exec_pending", 32'(exec_q.size()), 32'd0);
      check("cmd_exec_addr_held", 32'(execute_addr), 32'h5200);
      check("cmd_exec_low", 32'(execute_enable), 32'd0);

      // Index filter: CMD_INDEX bytes from HPS never reach the port
      ioctl_index    = 8'd2;
      ioctl_download = 1'b1;
      tick(2);
      check("filt_dn_go", 32'(dn_go), 32'd1);
      for (int i = 0; i < 3; i++) hps_write(16'(16'h3000 + i), 8'(8'h70 + i), 1'b1, 1'b0, 32'h0);
      tick(10);
      ioctl_download = 1'b0;
      wait_idle("filt_idle");

      // Reset mid-operation: queued bytes and pending execute are discarded
      loader_download = 1'b1;
      tick(2);
      dn_ready = 1'b0;
      for (int i = 0; i < 3; i++) loader_write(16'(16'h6000 + i), 8'(8'h90 + i));
      loader_exec_en   = 1'b1;
      loader_exec_addr = 16'h1234;
      tick();
      loader_exec_en = 1'b0;
      tick(2);
      check("mid_wait_before_reset", 32'(ioctl_wait), 32'd1);
      reset = 1'b1;
      exp_q.delete();
      exec_q.delete();
      tick();
      reset = 1'b0;
      check_all_zero("midreset");
      dn_ready    = 1'b1;
      last_wr_cyc = -1;
      exec_pulses = 0;
      tick(30);
      check("mid_no_fresh_edge", 32'(dn_go), 32'd0);
      loader_download = 1'b0;
      tick(10);
      check("mid_no_exec", 32'(exec_pulses), 32'd0);
      check("mid_overflow", 32'(overflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
